// File: rtl/ecc_pkg.sv
// Shared definitions for the SECDED Hamming codec: error labels, codeword
// layout helpers and the parameter legality check.
package ecc_pkg;

  typedef logic [2:0] label_t;

  localparam label_t LBL_NONE      = 3'b000;
  localparam label_t LBL_DATA_CORR = 3'b001;
  localparam label_t LBL_CHK_ERR   = 3'b010;
  localparam label_t LBL_OVR_ERR   = 3'b011;
  localparam label_t LBL_UNCORR    = 3'b100;

  localparam int MAX_DATA_WIDTH = 256;

  // Codeword position of data bit idx: the idx-th non-power-of-two position >= 3.
  function automatic int data_pos(input int idx);
    int cnt;
    int pos;
    cnt = 0;
    pos = 0;
    for (int p = 3; p < 1024; p++) begin
      if (pos == 0 && (p & (p - 1)) != 0) begin
        if (cnt == idx) pos = p;
        cnt++;
      end
    end
    return pos;
  endfunction

  // Data bits covered by check bit bit_idx.
  function automatic logic [MAX_DATA_WIDTH-1:0] check_mask(input int bit_idx, input int dw);
    logic [MAX_DATA_WIDTH-1:0] m;
    m = '0;
    for (int j = 0; j < dw; j++) begin
      if (((data_pos(j) >> bit_idx) & 1) != 0) m[j] = 1'b1;
    end
    return m;
  endfunction

  function automatic bit params_legal(input int dw, input int pl);
    return (dw >= 1) && (dw <= MAX_DATA_WIDTH) && (pl >= 2) && (pl <= 10) &&
           ((1 << pl) >= dw + pl + 1);
  endfunction

endpackage

// File: rtl/ecc_hamming_syndrome.sv
// Combinational Hamming syndrome and overall-parity mismatch generator,
// shared between the SECDED encoder and decoder.
module ecc_hamming_syndrome
  import ecc_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int PARITY_LENGTH = 6
) (
  input  logic [DATA_WIDTH-1:0]    d_in,
  input  logic [PARITY_LENGTH-1:0] parity_in,
  input  logic                     odd_even_parity,
  output logic [PARITY_LENGTH-1:0] syndrome,
  output logic                     mismatch
);

  logic [PARITY_LENGTH-1:0] recomputed;

  genvar gi;
  for (gi = 0; gi < PARITY_LENGTH; gi++) begin : g_check
    localparam logic [MAX_DATA_WIDTH-1:0] MASK = check_mask(gi, DATA_WIDTH);
    assign recomputed[gi] = ^(d_in & MASK[DATA_WIDTH-1:0]);
  end

  assign syndrome = recomputed ^ parity_in;
  // Stored codeword has even overall parity, so any odd count flags a mismatch.
  assign mismatch = (^d_in) ^ (^parity_in) ^ odd_even_parity;

endmodule

// File: rtl/ecc_hamming_secded_decoder.sv
// Registered SECDED Hamming decoder: one word per cycle, one cycle latency,
// corrects single-bit data errors and classifies all other error cases.
module ecc_hamming_secded_decoder
  import ecc_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int PARITY_LENGTH = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_WIDTH-1:0]    d_in,
  input  logic [PARITY_LENGTH-1:0] parity_in,
  input  logic                     odd_even_parity,
  output logic [DATA_WIDTH-1:0]    d_out_correct,
  output logic [2:0]               label_out,
  output logic                     odd_even_imm,
  output logic [PARITY_LENGTH-1:0] parity_imm
);

  localparam int CW_LEN = DATA_WIDTH + PARITY_LENGTH;

  if (!params_legal(DATA_WIDTH, PARITY_LENGTH)) begin : g_param_check
    $error("ecc_hamming_secded_decoder: illegal DATA_WIDTH/PARITY_LENGTH");
  end

  logic [PARITY_LENGTH-1:0] syndrome;
  logic                     mismatch;
  logic [DATA_WIDTH-1:0]    flip_hit;
  logic [DATA_WIDTH-1:0]    data_next;
  label_t                   label_next;
  logic                     syn_zero;
  logic                     syn_pow2;
  logic                     syn_in_range;

  ecc_hamming_syndrome #(
    .DATA_WIDTH   (DATA_WIDTH),
    .PARITY_LENGTH(PARITY_LENGTH)
  ) u_syndrome (
    .d_in           (d_in),
    .parity_in      (parity_in),
    .odd_even_parity(odd_even_parity),
    .syndrome       (syndrome),
    .mismatch       (mismatch)
  );

  genvar gi;
  for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_flip
    localparam int POS = data_pos(gi);
    assign flip_hit[gi] = (syndrome == PARITY_LENGTH'(POS));
  end

  assign syn_zero     = (syndrome == '0);
  assign syn_pow2     = ((syndrome & (syndrome - PARITY_LENGTH'(1))) == '0);
  assign syn_in_range = (int'(syndrome) <= CW_LEN);

  always_comb begin
    label_next = LBL_NONE;
    data_next  = d_in;
    if (syn_zero) begin
      label_next = mismatch ? LBL_OVR_ERR : LBL_NONE;
    end else if (!mismatch || !syn_in_range) begin
      label_next = LBL_UNCORR;
    end else if (syn_pow2) begin
      label_next = LBL_CHK_ERR;
    end else begin
      // Nonzero, in range, not a power of two: exactly one flip_hit bit is set.
      label_next = LBL_DATA_CORR;
      data_next  = d_in ^ flip_hit;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      d_out_correct <= '0;
      label_out     <= '0;
      odd_even_imm  <= 1'b0;
      parity_imm    <= '0;
    end else begin
      d_out_correct <= data_next;
      label_out     <= label_next;
      odd_even_imm  <= mismatch;
      parity_imm    <= syndrome;
    end
  end

endmodule

// File: tb/tb_ecc_hamming_secded_decoder.sv
// Self-checking bench for the SECDED decoder, using a codeword-level
// reference model (syndrome = XOR of positions of all set bits).
module tb_ecc_hamming_secded_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] d_in = '0;
  logic [5:0]  parity_in = '0;
  logic        odd_even_parity = 1'b0;
  logic [31:0] d_out_correct;
  logic [2:0]  label_out;
  logic        odd_even_imm;
  logic [5:0]  parity_imm;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ecc_hamming_secded_decoder #(.DATA_WIDTH(32), .PARITY_LENGTH(6)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .d_in           (d_in),
    .parity_in      (parity_in),
    .odd_even_parity(odd_even_parity),
    .d_out_correct  (d_out_correct),
    .label_out      (label_out),
    .odd_even_imm   (odd_even_imm),
    .parity_imm     (parity_imm)
  );

  // Packed result: {data[31:0], label[2:0], overall mismatch, syndrome[5:0]}
  function automatic logic [41:0] ref_model(input logic [31:0] d, input logic [5:0] p, input logic o);
    int          s;
    int          k;
    int          pi;
    int          dpos[32];
    logic        e;
    logic        b;
    logic [31:0] dc;
    logic [2:0]  lbl;
    s = 0; k = 0; pi = 0; e = o;
    for (int pos = 1; pos <= 38; pos++) begin
      if ((pos & (pos - 1)) == 0) begin
        b = p[pi];
        pi++;
      end else begin
        b = d[k];
        dpos[k] = pos;
        k++;
      end
      if (b) begin
        s = s ^ pos;
        e = ~e;
      end
    end
    dc = d;
    if (s == 0 && !e)               lbl = 3'b000;
    else if (s == 0)                lbl = 3'b011;
    else if (!e || s > 38)          lbl = 3'b100;
    else if ((s & (s - 1)) == 0)    lbl = 3'b010;
    else begin
      lbl = 3'b001;
      for (int j = 0; j < 32; j++) if (dpos[j] == s) dc[j] = ~dc[j];
    end
    return {dc, lbl, e, 6'(s)};
  endfunction

  function automatic logic [41:0] observed();
    return {d_out_correct, label_out, odd_even_imm, parity_imm};
  endfunction

  task automatic drive(input logic [31:0] d, input logic [5:0] p, input logic o);
    @(negedge clk);
    d_in = d;
    parity_in = p;
    odd_even_parity = o;
  endtask

  task automatic test_reset();
    logic [41:0] got;
    drive(32'h1, 6'h0, 1'b0);
    @(posedge clk); #1;
    drive($urandom, 6'($urandom), 1'($urandom));
    #2 rst_n = 1'b1;
    #1 got = observed();
    checks++;
    if (got !== 42'h0) begin
      errors++;
      $display("FAIL reset_async got=%h want=%h", got, 42'h0);
    end
    @(posedge clk); #1;
    got = observed();
    checks++;
    if (got !== 42'h0) begin
      errors++;
      $display("FAIL reset_held got=%h want=%h", got, 42'h0);
    end
    drive(32'h0, 6'h0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    got = observed();
    checks++;
    if (got !== 42'h0) begin
      errors++;
      $display("FAIL reset_first_word got=%h want=%h", got, 42'h0);
    end
    $display("test_reset: done");
  endtask

  task automatic test_single_data();
    logic [41:0] got;
    logic [41:0] exp;
    for (int i = 0; i < 32; i++) begin
      drive(32'h1 << i, 6'h0, 1'b0);
      @(posedge clk); #1;
      got = observed();
      exp = ref_model(32'h1 << i, 6'h0, 1'b0);
      checks++;
      if (got !== exp || got[41:10] !== 32'h0 || got[9:7] !== 3'b001) begin
        errors++;
        $display("FAIL single_data bit=%0d got=%h want=%h", i, got, exp);
      end else
        $display("single_data bit=%0d syn=%b label=%b ok", i, parity_imm, label_out);
    end
  endtask

  task automatic test_check_and_overall();
    logic [41:0] got;
    drive(32'h0, 6'b000100, 1'b0);
    @(posedge clk); #1;
    got = observed();
    checks++;
    if (got !== {32'h0, 3'b010, 1'b1, 6'b000100}) begin
      errors++;
      $display("FAIL check_bit got=%h want=%h", got, {32'h0, 3'b010, 1'b1, 6'b000100});
    end else $display("check_bit label=%b ok", label_out);
    drive(32'h0, 6'h0, 1'b1);
    @(posedge clk); #1;
    got = observed();
    checks++;
    if (got !== {32'h0, 3'b011, 1'b1, 6'b000000}) begin
      errors++;
      $display("FAIL overall_bit got=%h want=%h", got, {32'h0, 3'b011, 1'b1, 6'b000000});
    end else $display("overall_bit label=%b ok", label_out);
  endtask

  task automatic test_double_and_range();
    logic [41:0] got;
    drive(32'h3, 6'h0, 1'b0);
    @(posedge clk); #1;
    got = observed();
    checks++;
    if (got !== {32'h3, 3'b100, 1'b0, 6'b000110}) begin
      errors++;
      $display("FAIL double_err got=%h want=%h", got, {32'h3, 3'b100, 1'b0, 6'b000110});
    end else $display("double_err label=%b ok", label_out);
    drive(32'h0, 6'b101000, 1'b1);
    @(posedge clk); #1;
    got = observed();
    checks++;
    if (got !== {32'h0, 3'b100, 1'b1, 6'b101000}) begin
      errors++;
      $display("FAIL out_of_range got=%h want=%h", got, {32'h0, 3'b100, 1'b1, 6'b101000});
    end else $display("out_of_range label=%b ok", label_out);
  endtask

  task automatic test_back_to_back();
    logic [31:0] vd[5];
    logic [5:0]  vp[5];
    logic        vo[5];
    logic [41:0] got;
    logic [41:0] exp;
    vd = '{32'h1, 32'h0, 32'h0, 32'h3, 32'h0};
    vp = '{6'b000000, 6'b000100, 6'b000000, 6'b000000, 6'b101000};
    vo = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 5; k++) begin
      drive(vd[k], vp[k], vo[k]);
      @(posedge clk); #1;
      got = observed();
      exp = ref_model(vd[k], vp[k], vo[k]);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL back_to_back idx=%0d got=%h want=%h", k, got, exp);
      end else $display("back_to_back idx=%0d label=%b ok", k, label_out);
    end
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic [5:0]  p;
    logic        o;
    logic [41:0] exp;
    logic [41:0] got;
    int          nflip;
    int          r;
    for (int n = 0; n < 300; n++) begin
      d = $urandom;
      p = 6'($urandom);
      o = 1'($urandom);
      if (n % 5 != 4) begin
        // Build a valid even-parity codeword, then inject 0..2 bit flips.
        exp = ref_model(d, 6'h0, 1'b0);
        p = exp[5:0];
        o = (^d) ^ (^p);
        nflip = $urandom_range(0, 2);
        for (int f = 0; f < nflip; f++) begin
          r = $urandom_range(0, 38);
          if (r < 32)      d[r] = ~d[r];
          else if (r < 38) p[r-32] = ~p[r-32];
          else             o = ~o;
        end
      end
      drive(d, p, o);
      @(posedge clk); #1;
      got = observed();
      exp = ref_model(d, p, o);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random n=%0d d=%h p=%b o=%b got=%h want=%h", n, d, p, o, got, exp);
      end else
        $display("random n=%0d d=%h p=%b o=%b label=%b ok", n, d, p, o, label_out);
    end
  endtask

  initial begin
    test_reset();
    test_single_data();
    test_check_and_overall();
    test_double_and_range();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ecc_hamming_secded_decoder.md
Name: ecc_hamming_secded_decoder

Overview:
- Registered SECDED (single-error-correct, double-error-detect) Hamming decoder for the shared-memory read path in the CGRA memory subsystem.
- Takes a data word, its Hamming check bits and an overall parity bit as stored alongside the word.
- Recomputes the check bits and produces the syndrome, the overall-parity mismatch, corrected data and an error classification label.

Parameters:
- DATA_WIDTH, 32, data word width in bits.
- PARITY_LENGTH, 6, number of Hamming check bits. Must satisfy 2^PARITY_LENGTH >= DATA_WIDTH+PARITY_LENGTH+1.

Ports:
- clk  input  1  clock; all outputs update on its rising edge.
- rst_n  input  1  reset, asynchronous, active-high (name kept for codebase consistency; asserted = 1).
- d_in  input  DATA_WIDTH  received data word.
- parity_in  input  PARITY_LENGTH  received Hamming check bits; bit i has codeword position weight 2^i.
- odd_even_parity  input  1  received overall parity bit.
- d_out_correct  output  DATA_WIDTH  data word, single-bit error corrected.
- label_out  output  3  error classification.
- odd_even_imm  output  1  overall-parity mismatch flag.
- parity_imm  output  PARITY_LENGTH  syndrome.

Behaviour:
- Codeword layout:
  - Positions 1..DATA_WIDTH+PARITY_LENGTH.
  - Check bit i sits at position 2^i.
  - Data bits fill the remaining positions in ascending order: d_in[0] at position 3, d_in[1] at 5, d_in[2] at 6, d_in[3] at 7, d_in[4] at 9, and so on.
- Recomputed check bit i = XOR of all data bits whose position has bit i set.
- Syndrome s = recomputed check bits XOR parity_in.
- Overall mismatch e = (XOR of all d_in bits) XOR (XOR of all parity_in bits) XOR odd_even_parity. The stored codeword uses even overall parity.
- Classification (combinational, then registered):
  - s==0, e==0: label 3'b000, no error; data unchanged.
  - s!=0, e==1, s is a data position: label 3'b001; flip the data bit at position s.
  - s!=0, e==1, s a power of two: label 3'b010, check-bit error; data unchanged.
  - s==0, e==1: label 3'b011, overall-parity bit error; data unchanged.
  - s!=0, e==0: label 3'b100, double error, uncorrectable; data passed unchanged.
  - s > DATA_WIDTH+PARITY_LENGTH with e==1: label 3'b100, uncorrectable; data unchanged.
  - Codes 101–111 are never produced.
- Registered outputs: parity_imm = s, odd_even_imm = e, d_out_correct, label_out.
- Latency: exactly 1 cycle from inputs sampled at edge N to outputs valid after edge N. Fully pipelined, one new word per cycle, no handshake.
- Reset: while rst_n=1, all outputs are 0 immediately (asynchronous). The first valid output follows the first rising edge after deassertion. Asserting reset mid-stream discards the in-flight result.

Decomposition:
- Shared package (ecc_pkg):
  - label constants: LBL_NONE=000, LBL_DATA_CORR=001, LBL_CHK_ERR=010, LBL_OVR_ERR=011, LBL_UNCORR=100.
  - a function mapping data index to codeword position.
  - the DATA_WIDTH/PARITY_LENGTH legality check.
- One natural sub-module: ecc_hamming_syndrome (combinational syndrome and overall-parity generation). It is reusable by the matching encoder.

Test Plan:
- Reset: assert rst_n=1 with arbitrary inputs -> all outputs 0 with no clock edge; deassert, apply d_in=0, parity_in=0, odd_even_parity=0 -> next cycle d_out_correct=0, parity_imm=0, odd_even_imm=0, label 000.
- Single data error: d_in=32'h1, parity_in=0, odd_even_parity=0 -> parity_imm=6'b000011, odd_even_imm=1, d_out_correct=0, label 001. Repeat with each single data bit set; all are corrected to 0.
- Check-bit and overall-bit errors:
  - d_in=0, parity_in=6'b000100, odd_even_parity=0 -> parity_imm=6'b000100, odd_even_imm=1, d_out_correct=0, label 010.
  - d_in=0, parity_in=0, odd_even_parity=1 -> parity_imm=0, odd_even_imm=1, label 011.
- Double error: d_in=32'h3, parity_in=0, odd_even_parity=0 -> parity_imm=6'b000110, odd_even_imm=0, d_out_correct=32'h3, label 100.
- Out-of-range syndrome: d_in=0, parity_in=6'b101000, odd_even_parity=1 -> parity_imm=6'b101000, odd_even_imm=1, d_out_correct=0, label 100.
- Back-to-back throughput: apply the five vectors above on consecutive cycles -> each result appears exactly one cycle after its input, with no stalls and no cross-talk between words.
